// File: rtl/fifo_rd_scheduler_pkg.sv
// Shared types and helpers for the FIFO read scheduler: FSM state encoding,
// fixed timing constants and the round-robin search used by the picker.
package fifo_rd_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SWITCH,
        ST_SETTLE,
        ST_POP,
        ST_GAP,
        ST_DRAIN
    } state_t;

    localparam int SWITCH_TIMEOUT = 4;
    localparam int GAP_CYCLES     = 1;
    localparam int MAX_CHANNELS   = 32;

    // A single channel still needs a 1-bit index to keep port widths legal.
    function automatic int chan_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // First set request strictly after pointer, wrapping at n. Returns the
    // pointer itself when nothing is requested; callers qualify with |req.
    function automatic logic [31:0] rr_next(input logic [31:0]             pointer,
                                            input logic [MAX_CHANNELS-1:0] req,
                                            input int unsigned             n);
        logic [31:0] idx;
        logic        hit;
        rr_next = pointer;
        hit     = 1'b0;
        for (int unsigned k = 1; k <= MAX_CHANNELS; k++) begin
            idx = pointer + k;
            if (idx >= n) idx = idx - n;
            if (k <= n && !hit && req[idx[4:0]]) begin
                rr_next = idx;
                hit     = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/fifo_rd_scheduler_if.sv
// Selector-facing and host-facing signals of the read scheduler. Names are
// seen from the scheduler (master) side: o_* it drives, i_* it samples.
interface fifo_rd_scheduler_if
    import fifo_rd_scheduler_pkg::*;
#(
    parameter int CHANNEL_WIDTH = 32,
    parameter int CHANNEL_DEPTH = 1024,
    parameter int CHANNELS_CNT  = 3
);
    localparam int CW  = chan_width(CHANNELS_CNT);
    localparam int FCW = $clog2(CHANNEL_DEPTH) + 1;

    // Selector side
    logic [CW-1:0]            o_channel_rd_select;
    logic                     o_rd_en;
    logic [CW-1:0]            i_channel_rd_select;
    logic [CHANNEL_WIDTH-1:0] i_rd_data;
    logic                     i_rd_valid;
    logic [FCW-1:0]           i_fill_count;
    logic [CHANNELS_CNT-1:0]  i_rd_valid_channels;

    // Host readout stream
    logic [CHANNEL_WIDTH-1:0] o_data;
    logic [CW-1:0]            o_channel;
    logic                     o_last;
    logic                     o_valid;
    logic                     i_ready;

    modport master (
        output o_channel_rd_select, o_rd_en, o_data, o_channel, o_last, o_valid,
        input  i_channel_rd_select, i_rd_data, i_rd_valid, i_fill_count,
               i_rd_valid_channels, i_ready
    );

    modport slave (
        input  o_channel_rd_select, o_rd_en, o_data, o_channel, o_last, o_valid,
        output i_channel_rd_select, i_rd_data, i_rd_valid, i_fill_count,
               i_rd_valid_channels, i_ready
    );

endinterface

// File: rtl/fifo_rd_scheduler_rr_pick.sv
// Combinational round-robin picker: first requesting channel strictly after
// the pointer, wrapping circularly over CHANNELS_CNT requests.
module fifo_rd_scheduler_rr_pick
    import fifo_rd_scheduler_pkg::*;
#(
    parameter int CHANNELS_CNT = 3,
    parameter int CW           = chan_width(CHANNELS_CNT)
) (
    input  logic [CW-1:0]           pointer,
    input  logic [CHANNELS_CNT-1:0] req,
    output logic [CW-1:0]           pick,
    output logic                    found
);

    logic [MAX_CHANNELS-1:0] req_ext;
    logic [31:0]             next_idx;

    // NOTE: every always_comb output gets a default before any branch so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        req_ext                  = '0;
        req_ext[CHANNELS_CNT-1:0] = req;
        next_idx                 = rr_next(32'(pointer), req_ext, CHANNELS_CNT);
        pick                     = CW'(next_idx);
        found                    = |req;
    end

endmodule

// File: rtl/fifo_rd_scheduler.sv
// Round-robin burst reader for the multichannel FIFO selector. Hides the
// selector's switch latency and registered-data lag, emits a tagged stream.
module fifo_rd_scheduler
    import fifo_rd_scheduler_pkg::*;
#(
    parameter int CHANNEL_WIDTH = 32,
    parameter int CHANNEL_DEPTH = 1024,
    parameter int CHANNELS_CNT  = 3,
    parameter int BURST_MAX     = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_enable,
    fifo_rd_scheduler_if.master bus,
    output logic                o_busy,
    output logic [31:0]         o_words_drained
);

    localparam int CW  = chan_width(CHANNELS_CNT);
    localparam int FCW = $clog2(CHANNEL_DEPTH) + 1;
    localparam int BCW = $clog2(BURST_MAX + 1);
    localparam int WCW = $clog2(SWITCH_TIMEOUT + GAP_CYCLES + 1);

    state_t                   state_q,   state_d;
    logic [CW-1:0]            target_q,  target_d;
    logic [CW-1:0]            rr_ptr_q,  rr_ptr_d;
    logic [BCW-1:0]           burst_q,   burst_d;
    logic [WCW-1:0]           wait_q,    wait_d;
    logic [CW-1:0]            sel_q,     sel_d;
    logic                     rd_en_q,   rd_en_d;
    logic [CHANNEL_WIDTH-1:0] data_q,    data_d;
    logic [CW-1:0]            chan_q,    chan_d;
    logic                     last_q,    last_d;
    logic                     valid_q,   valid_d;
    logic                     busy_d;
    logic [31:0]              drained_d;

    logic [CW-1:0]            pick;
    logic                     pick_found;
    logic                     xfer;
    logic                     pop_last;

    fifo_rd_scheduler_rr_pick #(
        .CHANNELS_CNT (CHANNELS_CNT),
        .CW           (CW)
    ) u_rr_pick (
        .pointer (rr_ptr_q),
        .req     (bus.i_rd_valid_channels),
        .pick    (pick),
        .found   (pick_found)
    );

    assign bus.o_channel_rd_select = sel_q;
    assign bus.o_rd_en             = rd_en_q;
    assign bus.o_data              = data_q;
    assign bus.o_channel           = chan_q;
    assign bus.o_last              = last_q;
    assign bus.o_valid             = valid_q;

    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        rr_ptr_d  = rr_ptr_q;
        burst_d   = burst_q;
        wait_d    = wait_q;
        sel_d     = sel_q;
        rd_en_d   = 1'b0;
        data_d    = data_q;
        chan_d    = chan_q;
        last_d    = last_q;
        valid_d   = valid_q;
        drained_d = o_words_drained;

        xfer     = valid_q && bus.i_ready;
        pop_last = (burst_q == BCW'(BURST_MAX - 1)) ||
                   (bus.i_fill_count == FCW'(1));

        if (xfer) begin
            valid_d   = 1'b0;
            drained_d = o_words_drained + 32'd1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (i_enable && pick_found) begin
                    target_d = pick;
                    sel_d    = pick;
                    burst_d  = '0;
                    wait_d   = '0;
                    state_d  = ST_SWITCH;
                end
            end

            // A selector that never confirms the channel is a fault; give up
            // without advancing the pointer so the same channel is retried.
            ST_SWITCH: begin
                if (bus.i_channel_rd_select == target_q) begin
                    state_d = ST_SETTLE;
                end else if (wait_q == WCW'(SWITCH_TIMEOUT - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    wait_d = wait_q + WCW'(1);
                end
            end

            ST_SETTLE: state_d = ST_POP;

            ST_POP: begin
                if (!valid_q || xfer) begin
                    if (!bus.i_rd_valid) begin
                        state_d = ST_DRAIN;
                    end else begin
                        data_d  = bus.i_rd_data;
                        chan_d  = target_q;
                        valid_d = 1'b1;
                        last_d  = pop_last;
                        rd_en_d = 1'b1;
                        burst_d = burst_q + BCW'(1);
                        wait_d  = '0;
                        state_d = pop_last ? ST_DRAIN : ST_GAP;
                    end
                end
            end

            // The selector still presents the word just popped; skip it.
            ST_GAP: begin
                if (wait_q == WCW'(GAP_CYCLES - 1)) begin
                    state_d = ST_POP;
                end else begin
                    wait_d = wait_q + WCW'(1);
                end
            end

            ST_DRAIN: begin
                if (!valid_q) begin
                    rr_ptr_d = target_q;
                    state_d  = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            target_q        <= '0;
            rr_ptr_q        <= CW'(CHANNELS_CNT - 1);
            burst_q         <= '0;
            wait_q          <= '0;
            sel_q           <= '0;
            rd_en_q         <= 1'b0;
            data_q          <= '0;
            chan_q          <= '0;
            last_q          <= 1'b0;
            valid_q         <= 1'b0;
            o_busy          <= 1'b0;
            o_words_drained <= '0;
        end else begin
            state_q         <= state_d;
            target_q        <= target_d;
            rr_ptr_q        <= rr_ptr_d;
            burst_q         <= burst_d;
            wait_q          <= wait_d;
            sel_q           <= sel_d;
            rd_en_q         <= rd_en_d;
            data_q          <= data_d;
            chan_q          <= chan_d;
            last_q          <= last_d;
            valid_q         <= valid_d;
            o_busy          <= busy_d;
            o_words_drained <= drained_d;
        end
    end

endmodule

// File: doc/fifo_rd_scheduler.md
Name: fifo_rd_scheduler

Overview:
- Downstream consumer of the multichannel FIFO read selector. Drives the selector's channel-select and read-enable inputs.
- Serves non-empty channels round-robin, draining each in bursts of up to BURST_MAX words.
- Emits a channel-tagged valid/ready word stream toward the host readout path.
- Handles the selector's one-cycle switch latency and registered-data lag internally.

Parameters:
- CHANNEL_WIDTH, 32: data word width.
- CHANNEL_DEPTH, 1024: per-channel FIFO depth; fill count width is $clog2(CHANNEL_DEPTH)+1.
- CHANNELS_CNT, 3: number of channels; channel index width CW = $clog2(CHANNELS_CNT).
- BURST_MAX, 16: maximum words per channel visit, 1..CHANNEL_DEPTH.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- i_enable  in  1  scheduling enable; sampled in IDLE only.
- o_channel_rd_select  out  CW  requested channel, to the selector.
- o_rd_en  out  1  pop strobe, to the selector.
- i_channel_rd_select  in  CW  selector's actual registered channel.
- i_rd_data  in  CHANNEL_WIDTH  selector's registered head word.
- i_rd_valid  in  1  selector's registered valid.
- i_fill_count  in  $clog2(CHANNEL_DEPTH)+1  selector's registered fill count.
- i_rd_valid_channels  in  CHANNELS_CNT  per-channel data-present flags.
- o_data  out  CHANNEL_WIDTH  output word.
- o_channel  out  CW  source channel tag.
- o_last  out  1  final word of the burst.
- o_valid  out  1  output valid.
- i_ready  in  1  downstream ready.
- o_busy  out  1  high whenever state is not IDLE.
- o_words_drained  out  32  total words emitted, wraps at 2^32.

Behaviour:
- Reset values: o_channel_rd_select=0, o_rd_en=0, o_valid=0, o_last=0, o_data=0, o_channel=0, o_busy=0, o_words_drained=0; RR pointer=CHANNELS_CNT-1, so channel 0 is served first.
- Reset mid-burst aborts immediately. An in-flight output word is dropped. Any pop already issued is lost, which is accepted.
- o_rd_en is a registered, single-cycle pulse. All other outputs are registered.
- FSM states: IDLE, SWITCH, SETTLE, POP, GAP, DRAIN.
- IDLE: if i_enable and |i_rd_valid_channels, pick target = first set bit strictly after the RR pointer, circularly. Drive o_channel_rd_select=target, clear burst_cnt, go to SWITCH. Otherwise stay.
- SWITCH: wait until i_channel_rd_select==target, then go to SETTLE. Timeout after 4 cycles returns to IDLE with the RR pointer unchanged; this is treated as a selector fault.
- SETTLE: 1 cycle, so the registered data, valid and fill count reflect target. Then go to POP.
- POP: entered only when the output register is empty or being consumed this cycle (o_valid&&i_ready).
  - If i_rd_valid=0: go to DRAIN (channel empty).
  - Else: load o_data=i_rd_data, o_channel=target, o_valid=1. Pulse o_rd_en. Increment burst_cnt.
  - o_last=1 iff burst_cnt+1==BURST_MAX or i_fill_count==1.
  - Next state: GAP, or DRAIN if o_last.
- GAP: 1 mandatory bubble cycle after every pop. The selector's registered data still shows the popped word for one cycle and must not be re-read. Then go to POP.
- Throughput: at most 1 word per 2 cycles.
- DRAIN: wait until output register empty (o_valid=0). Set RR pointer=target, go to IDLE.
- Output handshake: o_valid holds with o_data, o_channel and o_last stable until i_ready. Transfer occurs on o_valid&&i_ready, which increments o_words_drained.
- i_ready low stalls in POP; no pop is issued while a word is held and not being consumed.
- If target empties mid-burst without last (fill estimate raced), POP sees i_rd_valid=0. The last emitted word then carries o_last=0; that is accepted.
- i_enable deassertion mid-burst takes effect only at the next IDLE.
- Single channel (CHANNELS_CNT=1, CW=1): RR always yields 0.

Decomposition:
- Package fifo_rd_scheduler_pkg holds:
  - state enum typedef;
  - SWITCH_TIMEOUT=4;
  - GAP_CYCLES=1;
  - function rr_next(pointer, request vector) returning the next channel index.
- One sub-module, rr_pick: combinational round-robin first-set-after-pointer search over CHANNELS_CNT bits. Verified standalone.

Test Plan:
- Ch1 holds 3 words (A,B,C), others empty, i_ready=1 → o_valid words A,B,C tagged ch1, 2 cycles apart; o_last on C; o_rd_en pulses exactly 3; o_words_drained=3.
- Ch0 20 words, ch2 5 words, BURST_MAX=16 → stream ch0×16 (last on 16th), ch2×5, ch0×4; order and tags exact; no duplicated or skipped word.
- i_ready low for 10 cycles mid-burst → o_data, o_channel and o_last held stable; no o_rd_en during the stall; resume without loss.
- Selector model never matches i_channel_rd_select → return to IDLE after 4 SWITCH cycles; no o_rd_en; o_busy falls.
- rst asserted asynchronously during POP → all outputs 0 in the same cycle; after release, the scheduler restarts at channel 0.
- i_enable=0 with all channels non-empty → stays IDLE, o_busy=0, no o_rd_en.
